fp_operand_loader: RTL and testbench

Byte-serial operand loader sitting directly upstream of the single-precision floating-point multiplier. It accepts a stream of 8-bit bytes over a valid/ready handshake and assembles two IEEE 754 single-precision operands, MSB byte first, A then B. It presents the completed pair on `dataA`/`dataB` with an `op_valid`/`op_ready` handshake. It also classifies each operand (zero, infinity, NaN) so the downstream multiplier path can override its result for special cases.

---
 rtl/fp_operand_loader.sv | 142 ++++++++++++++
 tb/tb_fp_operand_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_loader.sv
// Byte-serial loader that assembles two IEEE 754 single-precision operands, MSB byte first,
// and classifies each operand so the multiplier can short-circuit its special cases.
module fp_operand_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [2:0]  classA,
    output logic [2:0]  classB,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_A  = 2'd1,
        LOAD_B  = 2'd2,
        PRESENT = 2'd3
    } state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic        TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

    state_e      state_q;
    logic [1:0]  byteCnt_q;
    logic [15:0] idleCnt_q;
    logic [31:0] shA_q;
    logic [23:0] shB_q;
    logic [31:0] dataA_q;
    logic [31:0] dataB_q;
    logic [2:0]  classA_q;
    logic [2:0]  classB_q;
    logic        opValid_q;
    logic        timeoutErr_q;

    logic        accept;
    logic        frameBusy;
    logic        timeoutHit;
    logic [31:0] wordB_d;

    // Subnormals count as zero because the multiplier assumes a hidden leading 1.
    function automatic logic [2:0] classify(input logic [7:0] expo, input logic [22:0] mant);
        logic [2:0] cls;
        cls = 3'b000;
        if (expo == 8'h00) begin
            cls = 3'b001;
        end else if (expo == 8'hFF) begin
            cls = (mant == 23'd0) ? 3'b010 : 3'b100;
        end
        return cls;
    endfunction

    assign byte_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept     = byte_valid && byte_ready;
    assign frameBusy  = ((state_q == LOAD_A) && (byteCnt_q != 2'd0)) || (state_q == LOAD_B);
    assign timeoutHit = TIMEOUT_EN && frameBusy && !accept && ((idleCnt_q + 16'd1) == TIMEOUT_LIMIT);

    // Only the low three bytes of B need storing; the final byte comes straight from the input.
    assign wordB_d = {shB_q, byte_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byteCnt_q    <= 2'd0;
            idleCnt_q    <= 16'd0;
            shA_q        <= 32'd0;
            shB_q        <= 24'd0;
            dataA_q      <= 32'd0;
            dataB_q      <= 32'd0;
            classA_q     <= 3'b000;
            classB_q     <= 3'b000;
            opValid_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            timeoutErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= LOAD_A;
                end
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        byteCnt_q <= byteCnt_q + 2'd1;
                        idleCnt_q <= 16'd0;
                        if (state_q == LOAD_A) begin
                            shA_q <= {shA_q[23:0], byte_in};
                            if (byteCnt_q == 2'd3) begin
                                state_q <= LOAD_B;
                            end
                        end else begin
                            shB_q <= {shB_q[15:0], byte_in};
                            if (byteCnt_q == 2'd3) begin
                                dataA_q   <= shA_q;
                                dataB_q   <= wordB_d;
                                classA_q  <= classify(shA_q[30:23], shA_q[22:0]);
                                classB_q  <= classify(wordB_d[30:23], wordB_d[22:0]);
                                opValid_q <= 1'b1;
                                state_q   <= PRESENT;
                            end
                        end
                    end else if (timeoutHit) begin
                        state_q      <= LOAD_A;
                        byteCnt_q    <= 2'd0;
                        idleCnt_q    <= 16'd0;
                        shA_q        <= 32'd0;
                        shB_q        <= 24'd0;
                        timeoutErr_q <= 1'b1;
                    end else if (frameBusy) begin
                        if (idleCnt_q != 16'hFFFF) begin
                            idleCnt_q <= idleCnt_q + 16'd1;
                        end
                    end else begin
                        idleCnt_q <= 16'd0;
                    end
                end
                PRESENT: begin
                    idleCnt_q <= 16'd0;
                    if (op_ready) begin
                        opValid_q <= 1'b0;
                        state_q   <= LOAD_A;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dataA       = dataA_q;
    assign dataB       = dataB_q;
    assign classA      = classA_q;
    assign classB      = classB_q;
    assign op_valid    = opValid_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Bench for fp_operand_loader: two instances (timeout off and timeout 10) share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_fp_operand_loader;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] byteIn;
    logic byteValid;
    logic opReady;

    logic [1:0]       byteReady;
    logic [1:0]       opValid;
    logic [1:0]       terr;
    logic [1:0][31:0] dataA;
    logic [1:0][31:0] dataB;
    logic [1:0][2:0]  classA;
    logic [1:0][2:0]  classB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_operand_loader #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .byte_in(byteIn), .byte_valid(byteValid),
        .byte_ready(byteReady[0]), .dataA(dataA[0]), .dataB(dataB[0]),
        .op_valid(opValid[0]), .op_ready(opReady), .classA(classA[0]),
        .classB(classB[0]), .timeout_err(terr[0])
    );

    fp_operand_loader #(.TIMEOUT_CYCLES(10)) dut10 (
        .clk(clk), .reset(reset), .byte_in(byteIn), .byte_valid(byteValid),
        .byte_ready(byteReady[1]), .dataA(dataA[1]), .dataB(dataB[1]),
        .op_valid(opValid[1]), .op_ready(opReady), .classA(classA[1]),
        .classB(classB[1]), .timeout_err(terr[1])
    );

    // Reference model: a frame is just "bytes received so far" plus the pair last presented.
    bit          mBoot[2];
    bit          mPres[2];
    bit          mTerr[2];
    int          mN[2];
    int          mIdle[2];
    logic [63:0] mAcc[2];
    logic [31:0] mA[2];
    logic [31:0] mB[2];
    logic [2:0]  mCA[2];
    logic [2:0]  mCB[2];

    function automatic int timeoutOf(input int m);
        return (m == 0) ? 0 : 10;
    endfunction

    function automatic logic [2:0] refClass(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] f;
        e = v[30:23];
        f = v[22:0];
        if (e == 8'h00) return 3'b001;
        if (e == 8'hFF) return (f == 23'd0) ? 3'b010 : 3'b100;
        return 3'b000;
    endfunction

    function automatic bit modelReady(input int m);
        return !mBoot[m] && !mPres[m];
    endfunction

    task automatic modelReset(input int m);
        mBoot[m] = 1; mPres[m] = 0; mTerr[m] = 0; mN[m] = 0; mIdle[m] = 0;
        mAcc[m] = 64'd0; mA[m] = 32'd0; mB[m] = 32'd0; mCA[m] = 3'b000; mCB[m] = 3'b000;
    endtask

    task automatic modelStep(input int m);
        mTerr[m] = 0;
        if (mBoot[m]) begin
            mBoot[m] = 0;
        end else if (mPres[m]) begin
            if (opReady) mPres[m] = 0;
        end else if (byteValid) begin
            mAcc[m] = {mAcc[m][55:0], byteIn};
            mN[m] = mN[m] + 1;
            mIdle[m] = 0;
            if (mN[m] == 8) begin
                mA[m] = mAcc[m][63:32];
                mB[m] = mAcc[m][31:0];
                mCA[m] = refClass(mA[m]);
                mCB[m] = refClass(mB[m]);
                mPres[m] = 1;
                mN[m] = 0;
            end
        end else if (mN[m] > 0) begin
            if (timeoutOf(m) != 0 && mIdle[m] + 1 == timeoutOf(m)) begin
                mN[m] = 0; mAcc[m] = 64'd0; mIdle[m] = 0; mTerr[m] = 1;
            end else begin
                mIdle[m] = mIdle[m] + 1;
            end
        end
    endtask

    task automatic checkOutput(input int m);
        logic [72:0] act;
        logic [72:0] exp;
        act = {byteReady[m], opValid[m], dataA[m], dataB[m], classA[m], classB[m], terr[m]};
        exp = {modelReady(m), mPres[m], mA[m], mB[m], mCA[m], mCB[m], mTerr[m]};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL cycle dut%0d t=%0t got %h expected %h", m, $time, act, exp);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r);
        byteValid = v;
        byteIn    = b;
        opReady   = r;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            modelStep(0);
            modelStep(1);
        end
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
    endtask

    // Holds the byte until the chosen instance's model says it will be taken.
    task automatic sendByte(input logic [7:0] b, input int m);
        int guard;
        guard = 0;
        applyStimulus(1'b1, b, opReady);
        while (!modelReady(m) && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL sendByte wait got %0d expected <20", guard);
        end
        tick();
        byteValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int m);
        for (int i = 3; i >= 0; i--) begin
            sendByte(w[8*i +: 8], m);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset(0);
        modelReset(1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ca;
        logic [2:0]  cb;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] alphabet[6];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        bit hit;
        vecs[0] = '{32'h41480000, 32'hC0A66666, 3'b000, 3'b000};
        vecs[1] = '{32'h7F800000, 32'h7FC00000, 3'b010, 3'b100};
        vecs[2] = '{32'h00000000, 32'h80400000, 3'b001, 3'b001};
        vecs[3] = '{32'hFF800000, 32'h007FFFFF, 3'b010, 3'b001};
        vecs[4] = '{32'h7F800001, 32'h3F800000, 3'b100, 3'b000};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 3'b001, 3'b100};
        alphabet[0] = 8'h00; alphabet[1] = 8'h7F; alphabet[2] = 8'h80;
        alphabet[3] = 8'hFF; alphabet[4] = 8'hC0; alphabet[5] = 8'h3F;

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        modelReset(0);
        modelReset(1);
        #2;
        checkVal("reset dataA", dataA[0], 32'h0);
        checkVal("reset byte_ready", 32'(byteReady[0]), 32'h0);
        doReset();

        // Basic frame: op_valid lasts exactly one cycle when op_ready is held high.
        opReady = 1'b1;
        sendWord(32'h41480000, 0);
        sendWord(32'hC0A66666, 0);
        checkVal("basic valid", 32'(opValid[0]), 32'h1);
        checkVal("basic dataA", dataA[0], 32'h41480000);
        checkVal("basic dataB", dataB[0], 32'hC0A66666);
        tick();
        checkVal("basic valid drop", 32'(opValid[0]), 32'h0);

        // Backpressure: no bytes consumed while presenting, next frame starts with 3F.
        opReady = 1'b0;
        sendWord(32'h41480000, 0);
        sendWord(32'hC0A66666, 0);
        applyStimulus(1'b1, 8'h3F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVal("bp byte_ready", 32'(byteReady[0]), 32'h0);
            checkVal("bp dataB", dataB[0], 32'hC0A66666);
        end
        opReady = 1'b1;
        tick();
        opReady = 1'b0;
        tick();
        sendByte(8'h80, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendWord(32'h40000000, 0);
        checkVal("bp next dataA", dataA[0], 32'h3F800000);
        checkVal("bp next dataB", dataB[0], 32'h40000000);

        // Table of special-operand frames.
        doReset();
        foreach (vecs[k]) begin
            opReady = 1'b0;
            sendWord(vecs[k].a, 0);
            sendWord(vecs[k].b, 0);
            checkVal($sformatf("vec%0d dataA", k), dataA[0], vecs[k].a);
            checkVal($sformatf("vec%0d dataB", k), dataB[0], vecs[k].b);
            checkVal($sformatf("vec%0d classA", k), 32'(classA[0]), 32'(vecs[k].ca));
            checkVal($sformatf("vec%0d classB", k), 32'(classB[0]), 32'(vecs[k].cb));
            checkVal($sformatf("vec%0d valid", k), 32'(opValid[0]), 32'h1);
            applyStimulus(1'b0, 8'h00, 1'b1);
            tick();
        end

        // Timeout of 10 cycles after a 3-byte partial frame.
        doReset();
        opReady = 1'b1;
        sendByte(8'h41, 1);
        sendByte(8'h48, 1);
        sendByte(8'h00, 1);
        cnt = 0;
        hit = 0;
        while (!hit && cnt < 40) begin
            tick();
            cnt++;
            if (terr[1]) hit = 1;
        end
        checkVal("timeout delay", cnt, 32'd10);
        tick();
        checkVal("timeout width", 32'(terr[1]), 32'h0);
        sendWord(32'h3F800000, 1);
        sendWord(32'h40000000, 1);
        checkVal("after timeout dataA", dataA[1], 32'h3F800000);
        checkVal("after timeout dataB", dataB[1], 32'h40000000);

        // Timeout disabled: a long gap does not break the frame.
        doReset();
        opReady = 1'b1;
        sendByte(8'h41, 0);
        sendByte(8'h48, 0);
        sendByte(8'h00, 0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (terr[0]) cnt++;
        end
        checkVal("no timeout pulses", cnt, 32'd0);
        sendByte(8'h00, 0);
        sendWord(32'hC0A66666, 0);
        checkVal("gap frame valid", 32'(opValid[0]), 32'h1);
        checkVal("gap frame dataA", dataA[0], 32'h41480000);
        checkVal("gap frame dataB", dataB[0], 32'hC0A66666);

        // Asynchronous reset between edges after 6 bytes.
        doReset();
        opReady = 1'b0;
        sendWord(32'h3F800000, 0);
        sendWord(32'h7F800000, 0);
        opReady = 1'b1;
        tick();
        opReady = 1'b0;
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        sendByte(8'h33, 0);
        sendByte(8'h44, 0);
        sendByte(8'h55, 0);
        sendByte(8'h66, 0);
        #2;
        reset = 1'b1;
        modelReset(0);
        modelReset(1);
        #1;
        checkVal("async rst byte_ready", 32'(byteReady[0]), 32'h0);
        checkVal("async rst dataA", dataA[0], 32'h0);
        checkOutput(0);
        checkOutput(1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sendByte(8'(8'h10 + i), 0);
        end
        checkVal("rst 7 bytes valid", 32'(opValid[0]), 32'h0);
        sendByte(8'h17, 0);
        checkVal("rst 8 bytes valid", 32'(opValid[0]), 32'h1);
        checkVal("rst frame dataA", dataA[0], 32'h10111213);
        checkVal("rst frame dataB", dataB[0], 32'h14151617);

        // Randomized traffic with occasional idle bursts long enough to trip the timeout.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 1) == 0) ? alphabet[$urandom_range(0, 5)] : 8'($urandom);
            if ((i % 250) == 0) begin
                applyStimulus(1'b0, b, 1'b1);
                repeat ($urandom_range(8, 14)) tick();
            end
            applyStimulus(($urandom % 100) < 75, b, ($urandom % 4) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
